// File: rtl/test_binop_checker.sv
// test_binop_checker
// Self-checking stimulus generator and result checker for two-operand,
// one-result DUTs. It drives NUM_VEC deterministic operand pairs and
// computes the golden result for each pair. The golden result is delayed
// by the DUT latency and then compared with y. The block reports a sticky
// fail flag, a saturating error count and the index of the first mismatch.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   y             in   DUT result (WIDTH)
//   a, b          out  registered DUT operands (WIDTH)
//   fail          out  sticky, at least one mismatch seen
//   finish        out  sticky, run complete
//   err_count     out  mismatch count, saturating (CNT_W)
//   first_err_idx out  vector index of the first mismatch (32)
module test_binop_checker #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned OP           = 0,
    parameter int unsigned NUM_VEC      = 16,
    parameter int unsigned LATENCY      = 0,
    parameter int unsigned SEED_A       = 15,
    parameter int unsigned SEED_B       = 15,
    parameter int unsigned INC_A        = 1,
    parameter int unsigned INC_B        = 3,
    parameter int unsigned STOP_ON_FAIL = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             fail,
    output logic             finish,
    output logic [CNT_W-1:0] err_count,
    output logic [31:0]      first_err_idx
);

    localparam logic [31:0] LAST_IDX = 32'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] vec_idx;
    logic [31:0] cmp_idx;

    logic [WIDTH-1:0] exp_c;
    logic             cmp_valid_c;
    logic [WIDTH-1:0] cmp_exp_c;

    // Golden operation; add/sub wrap modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        case (OP)
            0:       r = ~(x & z);
            1:       r = x & z;
            2:       r = x | z;
            3:       r = x ^ z;
            4:       r = x + z;
            5:       r = x - z;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign exp_c = golden(a, b);

    // Expected-value delay line that aligns the golden result with y.
    if (LATENCY == 0) begin : g_comb
        assign cmp_valid_c = (state == S_RUN);
        assign cmp_exp_c   = exp_c;
    end else begin : g_pipe
        logic [WIDTH-1:0] exp_q [LATENCY];
        logic [LATENCY-1:0] vld_q;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_q <= '0;
                for (int i = 0; i < LATENCY; i++) begin
                    exp_q[i] <= '0;
                end
            end else begin
                // Only RUN pushes valid entries; DRAIN and DONE push bubbles.
                vld_q[0] <= (state == S_RUN);
                exp_q[0] <= exp_c;
                for (int i = 1; i < LATENCY; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    exp_q[i] <= exp_q[i-1];
                end
            end
        end

        assign cmp_valid_c = vld_q[LATENCY-1];
        assign cmp_exp_c   = exp_q[LATENCY-1];
    end

    // Run control, operand generation and result checking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_RUN;
            vec_idx       <= '0;
            cmp_idx       <= '0;
            a             <= WIDTH'(SEED_A);
            b             <= WIDTH'(SEED_B);
            fail          <= 1'b0;
            finish        <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            if (state == S_RUN) begin
                if (vec_idx != LAST_IDX) begin
                    a       <= a + WIDTH'(INC_A);
                    b       <= b + WIDTH'(INC_B);
                    vec_idx <= vec_idx + 32'd1;
                end else begin
                    state <= (LATENCY == 0) ? S_DONE : S_DRAIN;
                end
            end

            // Entries still in flight after an early stop are ignored in DONE.
            if (state != S_DONE && cmp_valid_c) begin
                cmp_idx <= cmp_idx + 32'd1;
                if (y != cmp_exp_c) begin
                    fail <= 1'b1;
                    if (err_count != {CNT_W{1'b1}}) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    if (!fail) begin
                        first_err_idx <= cmp_idx;
                    end
                    if (STOP_ON_FAIL != 0) begin
                        finish <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                if (cmp_idx == LAST_IDX) begin
                    finish <= 1'b1;
                    state  <= S_DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_test_binop_checker.sv
// Directed testbench for test_binop_checker. Five checker instances with
// different parameter sets each drive a small behavioural DUT. Every test
// task resets all instances and then samples their outputs at chosen cycles.
module tb_test_binop_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cur = 0;

    always #5 clk = ~clk;

    // u1: nand, 1 vector, combinational correct DUT
    logic [7:0] a1, b1, y1;
    logic fail1, fin1;
    logic [15:0] err1;
    logic [31:0] idx1;
    assign y1 = ~(a1 & b1);
    test_binop_checker #(.WIDTH(8), .OP(0), .NUM_VEC(1), .LATENCY(0)) u1 (
        .clock(clk), .reset(rst_n), .y(y1), .a(a1), .b(b1), .fail(fail1),
        .finish(fin1), .err_count(err1), .first_err_idx(idx1));

    // u2: add, 16 vectors, correct 2-stage DUT
    logic [7:0] a2, b2, y2, p2a;
    logic fail2, fin2;
    logic [15:0] err2;
    logic [31:0] idx2;
    always @(posedge clk) begin p2a <= a2 + b2; y2 <= p2a; end
    test_binop_checker #(.WIDTH(8), .OP(4), .NUM_VEC(16), .LATENCY(2)) u2 (
        .clock(clk), .reset(rst_n), .y(y2), .a(a2), .b(b2), .fail(fail2),
        .finish(fin2), .err_count(err2), .first_err_idx(idx2));

    // u3: as u2, but the DUT outputs 0 for vector 5 (a=14h, b=1Eh)
    logic [7:0] a3, b3, y3, p3a;
    logic fail3, fin3;
    logic [15:0] err3;
    logic [31:0] idx3;
    always @(posedge clk) begin
        p3a <= (a3 == 8'h14 && b3 == 8'h1E) ? 8'h00 : a3 + b3;
        y3  <= p3a;
    end
    test_binop_checker #(.WIDTH(8), .OP(4), .NUM_VEC(16), .LATENCY(2)) u3 (
        .clock(clk), .reset(rst_n), .y(y3), .a(a3), .b(b3), .fail(fail3),
        .finish(fin3), .err_count(err3), .first_err_idx(idx3));

    // u4: 4-bit sub with stop-on-fail; the DUT wrongly computes b-a
    logic [3:0] a4, b4, y4;
    logic fail4, fin4;
    logic [15:0] err4;
    logic [31:0] idx4;
    assign y4 = b4 - a4;
    test_binop_checker #(.WIDTH(4), .OP(5), .SEED_A(0), .SEED_B(1),
                         .STOP_ON_FAIL(1)) u4 (
        .clock(clk), .reset(rst_n), .y(y4), .a(a4), .b(b4), .fail(fail4),
        .finish(fin4), .err_count(err4), .first_err_idx(idx4));

    // u5: 16-bit xor, 100 vectors, 3-stage DUT that always inverts its result
    logic [15:0] a5, b5, y5, p5a, p5b;
    logic fail5, fin5;
    logic [15:0] err5;
    logic [31:0] idx5;
    always @(posedge clk) begin p5a <= ~(a5 ^ b5); p5b <= p5a; y5 <= p5b; end
    test_binop_checker #(.WIDTH(16), .OP(3), .NUM_VEC(100), .LATENCY(3)) u5 (
        .clock(clk), .reset(rst_n), .y(y5), .a(a5), .b(b5), .fail(fail5),
        .finish(fin5), .err_count(err5), .first_err_idx(idx5));

    // Hold reset for two cycles, then release on a falling edge (start of cycle 0).
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
    endtask

    // Advance to the falling edge inside cycle c.
    task automatic at_cycle(input int c);
        while (cur < c) begin
            @(posedge clk);
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (a2 !== 8'h0F || b2 !== 8'h0F) begin fails++; $display("FAIL reset_ab2 a=%h b=%h exp 0f/0f", a2, b2); end
        tests++; if (a4 !== 4'h0 || b4 !== 4'h1) begin fails++; $display("FAIL reset_ab4 a=%h b=%h exp 0/1", a4, b4); end
        tests++; if ({fail2, fin2, fail4, fin4} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {fail2, fin2, fail4, fin4}); end
        tests++; if (err5 !== 16'd0 || idx5 !== 32'd0) begin fails++; $display("FAIL reset_cnt err=%0d idx=%0d exp 0/0", err5, idx5); end
    endtask

    task automatic test_nand_single();
        do_reset();
        tests++; if (a1 !== 8'h0F || b1 !== 8'h0F || y1 !== 8'hF0) begin fails++; $display("FAIL nand_vec a=%h b=%h y=%h", a1, b1, y1); end
        tests++; if (fin1 !== 1'b0) begin fails++; $display("FAIL nand_fin0 got %b exp 0", fin1); end
        at_cycle(1);
        tests++; if (fin1 !== 1'b1 || fail1 !== 1'b0 || err1 !== 16'd0) begin fails++; $display("FAIL nand_done fin=%b fail=%b err=%0d exp 1/0/0", fin1, fail1, err1); end
        at_cycle(3);
        tests++; if (a1 !== 8'h0F || b1 !== 8'h0F) begin fails++; $display("FAIL nand_hold a=%h b=%h exp 0f/0f", a1, b1); end
    endtask

    task automatic test_add_pipe();
        do_reset();
        at_cycle(17);
        tests++; if (fin2 !== 1'b0) begin fails++; $display("FAIL add_fin17 got %b exp 0", fin2); end
        at_cycle(18);
        tests++; if (fin2 !== 1'b1 || fail2 !== 1'b0 || err2 !== 16'd0) begin fails++; $display("FAIL add_fin18 fin=%b fail=%b err=%0d exp 1/0/0", fin2, fail2, err2); end
        tests++; if (a2 !== 8'h1E || b2 !== 8'h3C) begin fails++; $display("FAIL add_hold a=%h b=%h exp 1e/3c", a2, b2); end
    endtask

    task automatic test_add_fault();
        do_reset();
        at_cycle(7);
        tests++; if (fail3 !== 1'b0) begin fails++; $display("FAIL fault_early got %b exp 0", fail3); end
        at_cycle(8);
        tests++; if (fail3 !== 1'b1 || err3 !== 16'd1 || idx3 !== 32'd5) begin fails++; $display("FAIL fault_c8 fail=%b err=%0d idx=%0d exp 1/1/5", fail3, err3, idx3); end
        at_cycle(17);
        tests++; if (fin3 !== 1'b0) begin fails++; $display("FAIL fault_fin17 got %b exp 0", fin3); end
        at_cycle(18);
        tests++; if (fin3 !== 1'b1 || err3 !== 16'd1) begin fails++; $display("FAIL fault_fin18 fin=%b err=%0d exp 1/1", fin3, err3); end
    endtask

    task automatic test_sub_stop();
        do_reset();
        tests++; if (fail4 !== 1'b0 || fin4 !== 1'b0) begin fails++; $display("FAIL stop_c0 fail=%b fin=%b exp 0/0", fail4, fin4); end
        at_cycle(1);
        tests++; if (fail4 !== 1'b1 || fin4 !== 1'b1) begin fails++; $display("FAIL stop_c1 fail=%b fin=%b exp 1/1", fail4, fin4); end
        tests++; if (err4 !== 16'd1 || idx4 !== 32'd0) begin fails++; $display("FAIL stop_cnt err=%0d idx=%0d exp 1/0", err4, idx4); end
        at_cycle(5);
        tests++; if (a4 !== 4'h1 || b4 !== 4'h4 || err4 !== 16'd1) begin fails++; $display("FAIL stop_frozen a=%h b=%h err=%0d exp 1/4/1", a4, b4, err4); end
    endtask

    task automatic test_xor_always_wrong();
        do_reset();
        at_cycle(102);
        tests++; if (fin5 !== 1'b0 || err5 !== 16'd99) begin fails++; $display("FAIL xor_c102 fin=%b err=%0d exp 0/99", fin5, err5); end
        at_cycle(103);
        tests++; if (fin5 !== 1'b1 || fail5 !== 1'b1) begin fails++; $display("FAIL xor_done fin=%b fail=%b exp 1/1", fin5, fail5); end
        tests++; if (err5 !== 16'd100 || idx5 !== 32'd0) begin fails++; $display("FAIL xor_cnt err=%0d idx=%0d exp 100/0", err5, idx5); end
        at_cycle(110);
        tests++; if (err5 !== 16'd100) begin fails++; $display("FAIL xor_frozen err=%0d exp 100", err5); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        at_cycle(7);
        tests++; if (err5 !== 16'd4 || a2 !== 8'h16) begin fails++; $display("FAIL mid_pre err=%0d a2=%h exp 4/16", err5, a2); end
        rst_n = 1'b0;
        #1;
        tests++; if (a2 !== 8'h0F || b2 !== 8'h0F || err5 !== 16'd0 || fail5 !== 1'b0) begin fails++; $display("FAIL mid_async a2=%h b2=%h err5=%0d fail5=%b", a2, b2, err5, fail5); end
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
        at_cycle(8);
        tests++; if (fail3 !== 1'b1 || idx3 !== 32'd5 || err3 !== 16'd1) begin fails++; $display("FAIL mid_fault fail=%b idx=%0d err=%0d exp 1/5/1", fail3, idx3, err3); end
        at_cycle(17);
        tests++; if (fin2 !== 1'b0) begin fails++; $display("FAIL mid_fin17 got %b exp 0", fin2); end
        at_cycle(18);
        tests++; if (fin2 !== 1'b1 || fail2 !== 1'b0 || a2 !== 8'h1E) begin fails++; $display("FAIL mid_fin18 fin=%b fail=%b a=%h exp 1/0/1e", fin2, fail2, a2); end
    endtask

    initial begin
        test_reset();
        test_nand_single();
        test_add_pipe();
        test_add_fault();
        test_sub_stop();
        test_xor_always_wrong();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
